// File: rtl/irq_controller.sv
// External-interrupt scheduler: edge-latched sources, priority/threshold arbitration, claim/complete handshake; optional IRQC_ACK_TIMEOUT_EN.
// Latency: edge -> pending 1 cycle, pending -> interrupt_vector 1 cycle; bus reads registered (1 cycle).
// Backpressure: none on the bus; PRESENT holds until interrupt_ack (or timeout when IRQC_ACK_TIMEOUT_EN is defined).
module irq_controller #(
  parameter int          NUM_SRC     = 8,
  parameter logic [63:0] BASE_ADDR   = 64'h10000000,
  parameter int          ACK_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic [3:0]         interrupt_vector,
  input  logic               interrupt_ack,
  input  logic [63:0]        bus_address,
  input  logic [63:0]        bus_write_data,
  input  logic               bus_write_enable,
  input  logic               bus_read_enable,
  output logic [63:0]        bus_read_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, PRESENT = 2'd1, IN_SVC = 2'd2} state_t;

  state_t             state, state_n;
  logic [NUM_SRC-1:0] pending, enable, irq_prev, pend_clr;
  logic [2:0]         prio [NUM_SRC];
  logic [2:0]         threshold;
  logic [3:0]         claim_id, best_id;
  logic [2:0]         best_prio;
  logic               any_elig, take_ack, wr_hit, complete_wr;
  logic [63:0]        offset, rd_val;
  logic [7:0]         off;
  logic               in_window, rd_hit;
  logic               unused_bits;

`ifdef IRQC_ACK_TIMEOUT_EN
  logic [7:0] ack_cnt;
  logic       status, timeout_hit;
`endif

  assign offset      = bus_address - BASE_ADDR;
  assign in_window   = (bus_address >= BASE_ADDR) && (offset < 64'h100);
  assign off         = offset[7:0];
  assign wr_hit      = bus_write_enable && in_window;
  assign complete_wr = wr_hit && (off == 8'h20);
  assign unused_bits = ^{bus_write_data, offset, 32'(ACK_TIMEOUT)};

  // Strictly-greater compare while scanning upward keeps ties on the lowest index.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending[i] && enable[i] && (prio[i] > threshold) && (prio[i] > best_prio)) begin
        best_prio = prio[i];
        best_id   = 4'(i + 1);
      end
    end
  end

  assign any_elig = (best_id != 4'd0);

  always_comb begin
    pend_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (take_ack && (best_id == 4'(i + 1))) pend_clr[i] = 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    take_ack = 1'b0;
`ifdef IRQC_ACK_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: if (any_elig) state_n = PRESENT;
      PRESENT: begin
        if (interrupt_ack) begin
          take_ack = 1'b1;
          state_n  = any_elig ? IN_SVC : IDLE;
        end else if (!any_elig) state_n = IDLE;
`ifdef IRQC_ACK_TIMEOUT_EN
        else if (ack_cnt == 8'(ACK_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_n     = IDLE;
        end
`endif
      end
      IN_SVC: if (complete_wr && (bus_write_data[3:0] == claim_id)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign interrupt_vector = {3'b000, state == PRESENT};

  always_comb begin
    rd_val = '0;
    rd_hit = 1'b0;
    if (in_window && (off[2:0] == 3'b000)) begin
      rd_hit = 1'b1;
      case (off)
        8'h00: rd_val[NUM_SRC-1:0] = pending;
        8'h08: rd_val[NUM_SRC-1:0] = enable;
        8'h10: rd_val[2:0] = threshold;
        8'h18: rd_val[3:0] = claim_id;
        8'h20: rd_val = '0;
        8'h28: begin
`ifdef IRQC_ACK_TIMEOUT_EN
          rd_val[0] = status;
`endif
        end
        default: begin
          rd_hit = 1'b0;
          for (int i = 0; i < NUM_SRC; i++) begin
            if (off == 8'(64 + 8 * i)) begin
              rd_hit      = 1'b1;
              rd_val[2:0] = prio[i];
            end
          end
        end
      endcase
    end
  end

  // irq_prev tracks the line even in reset so a level held across reset is not seen as an edge.
  always_ff @(posedge clk) begin
    irq_prev <= irq_src;
    if (reset) begin
      state         <= IDLE;
      pending       <= '0;
      enable        <= '0;
      threshold     <= '0;
      claim_id      <= '0;
      bus_read_data <= '0;
      for (int i = 0; i < NUM_SRC; i++) prio[i] <= '0;
    end else begin
      state   <= state_n;
      pending <= (pending & ~pend_clr) | (irq_src & ~irq_prev);
      if (take_ack) claim_id <= best_id;
      if (bus_read_enable && rd_hit) bus_read_data <= rd_val;
      if (wr_hit && (off == 8'h08)) enable <= bus_write_data[NUM_SRC-1:0];
      if (wr_hit && (off == 8'h10)) threshold <= bus_write_data[2:0];
      for (int i = 0; i < NUM_SRC; i++) begin
        if (wr_hit && (off == 8'(64 + 8 * i))) prio[i] <= bus_write_data[2:0];
      end
    end
  end

`ifdef IRQC_ACK_TIMEOUT_EN
  // Counter idles at zero outside PRESENT, so every entry starts a fresh window.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_cnt <= '0;
      status  <= 1'b0;
    end else begin
      ack_cnt <= (state == PRESENT) ? ack_cnt + 8'd1 : 8'd0;
      if (timeout_hit) status <= 1'b1;
      else if (wr_hit && (off == 8'h28) && bus_write_data[0]) status <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: register table, directed handshake sequences, random run vs. reference model.
module tb_irq_controller;
  localparam int          NS   = 8;
  localparam logic [63:0] BASE = 64'h10000000;
`ifdef IRQC_ACK_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 64;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NS-1:0] irq_src = '0;
  logic [3:0]    interrupt_vector;
  logic          interrupt_ack = 1'b0;
  logic [63:0]   bus_address = '0;
  logic [63:0]   bus_write_data = '0;
  logic          bus_write_enable = 1'b0;
  logic          bus_read_enable = 1'b0;
  logic [63:0]   bus_read_data;

  irq_controller #(.NUM_SRC(NS), .BASE_ADDR(BASE), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .interrupt_vector(interrupt_vector),
    .interrupt_ack(interrupt_ack), .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_write_enable(bus_write_enable), .bus_read_enable(bus_read_enable), .bus_read_data(bus_read_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [63:0] o, input logic [63:0] d);
    bus_address = BASE + o; bus_write_data = d; bus_write_enable = 1'b1;
    tick();
    bus_write_enable = 1'b0;
  endtask

  task automatic bus_rd(input logic [63:0] o);
    bus_address = BASE + o; bus_read_enable = 1'b1;
    tick();
    bus_read_enable = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; irq_src = '0; interrupt_ack = 1'b0;
    bus_write_enable = 1'b0; bus_read_enable = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic serve(input int exp_id, input string nm);
    int n = 0;
    while (interrupt_vector !== 4'd1 && n < 10) begin tick(); n++; end
    chk({nm, "_vec"}, interrupt_vector, 4'd1);
    interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
    chk({nm, "_vec_off"}, interrupt_vector, 4'd0);
    bus_rd(64'h18);
    chk({nm, "_claim"}, bus_read_data, 64'(exp_id));
    bus_wr(64'h20, 64'(exp_id));
  endtask

  // ---------------- register table ----------------
  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    bit          wr;
    bit          rd;
    logic [63:0] exp_rd;
    string       name;
  } vec_t;

  function automatic vec_t mk(input logic [63:0] a, input logic [63:0] d, input bit w, input bit r,
                              input logic [63:0] e, input string n);
    vec_t v;
    v.addr = a; v.wdata = d; v.wr = w; v.rd = r; v.exp_rd = e; v.name = n;
    return v;
  endfunction

  // ---------------- reference model ----------------
  int          m_st;  // 0 waiting, 1 presenting, 2 in service
  logic [7:0]  m_pend, m_en, m_prev;
  int          m_prio [NS];
  int          m_thr, m_claim, m_cnt;
  bit          m_status;
  logic [63:0] m_rd;

  task automatic m_reset();
    m_st = 0; m_pend = '0; m_en = '0; m_prev = '0; m_thr = 0; m_claim = 0;
    m_cnt = 0; m_status = 0; m_rd = '0;
    for (int i = 0; i < NS; i++) m_prio[i] = 0;
  endtask

  // Highest priority level first, then lowest index within that level.
  function automatic int m_best();
    for (int p = 7; p >= 1; p--) begin
      if (p <= m_thr) return 0;
      for (int i = 0; i < NS; i++)
        if (m_pend[i] && m_en[i] && m_prio[i] == p) return i + 1;
    end
    return 0;
  endfunction

  function automatic bit m_mapped(input logic [63:0] o);
    if (o == 0 || o == 8 || o == 16 || o == 24 || o == 32 || o == 40) return 1;
    return (o >= 64) && (o < 64 + 8 * NS) && (o % 8 == 0);
  endfunction

  function automatic logic [63:0] m_val(input logic [63:0] o);
    case (o)
      64'h00: return 64'(m_pend);
      64'h08: return 64'(m_en);
      64'h10: return 64'(m_thr);
      64'h18: return 64'(m_claim);
      64'h20: return 64'h0;
`ifdef IRQC_ACK_TIMEOUT_EN
      64'h28: return 64'(m_status);
`else
      64'h28: return 64'h0;
`endif
      default: return 64'(m_prio[(o - 64) / 8]);
    endcase
  endfunction

  task automatic m_step(input logic [7:0] src, input bit ack, input logic [63:0] addr,
                        input logic [63:0] wd, input bit we, input bit re);
    int best, nst;
    bit inw, tmo;
    logic [63:0] o;
    logic [7:0] clr;
    best = m_best();
    inw  = (addr >= BASE) && ((addr - BASE) < 64'h100);
    o    = addr - BASE;
    clr  = '0;
    tmo  = 0;
    nst  = m_st;
    if (re && inw && m_mapped(o)) m_rd = m_val(o);
    if (m_st == 0) begin
      if (best != 0) begin nst = 1; m_cnt = 0; end
    end else if (m_st == 1) begin
      if (ack) begin
        m_claim = best;
        if (best != 0) begin clr[best-1] = 1'b1; nst = 2; end
        else nst = 0;
      end else if (best == 0) nst = 0;
`ifdef IRQC_ACK_TIMEOUT_EN
      else if (m_cnt == TO - 1) begin nst = 0; tmo = 1; m_status = 1; end
      else m_cnt++;
`endif
    end else begin
      if (we && inw && o == 64'h20 && int'(wd[3:0]) == m_claim) nst = 0;
    end
    m_pend = (m_pend & ~clr) | (src & ~m_prev);
    m_prev = src;
    if (we && inw) begin
      if (o == 64'h08) m_en = wd[7:0];
      if (o == 64'h10) m_thr = int'(wd[2:0]);
      if (o == 64'h28 && wd[0] && !tmo) m_status = 0;
      if (o >= 64 && o < 64 + 8 * NS && o % 8 == 0) m_prio[(o - 64) / 8] = int'(wd[2:0]);
    end
    m_st = nst;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [16];
    logic [63:0] roffs [12];

    vt[0]  = mk(BASE + 64'h00, 64'h0, 0, 1, 64'h0, "pending_rst");
    vt[1]  = mk(BASE + 64'h08, 64'h0, 0, 1, 64'h0, "enable_rst");
    vt[2]  = mk(BASE + 64'h18, 64'h0, 0, 1, 64'h0, "claim_rst");
    vt[3]  = mk(BASE + 64'h08, 64'hFFFF_FFFF_FFFF_FFA5, 1, 0, 64'h0, "enable_wr_rd_hold");
    vt[4]  = mk(BASE + 64'h08, 64'h0, 0, 1, 64'hA5, "enable_rd");
    vt[5]  = mk(BASE + 64'h10, 64'hFF, 1, 0, 64'hA5, "thr_wr_rd_hold");
    vt[6]  = mk(BASE + 64'h10, 64'h0, 0, 1, 64'h7, "thr_rd");
    vt[7]  = mk(BASE + 64'h58, 64'h1D, 1, 0, 64'h7, "prio3_wr");
    vt[8]  = mk(BASE + 64'h58, 64'h0, 0, 1, 64'h5, "prio3_rd");
    vt[9]  = mk(BASE + 64'h30, 64'h0, 0, 1, 64'h5, "unmapped_rd_hold");
    vt[10] = mk(BASE + 64'h100, 64'h0, 0, 1, 64'h5, "above_window_hold");
    vt[11] = mk(BASE - 64'h8, 64'h0, 0, 1, 64'h5, "below_window_hold");
    vt[12] = mk(BASE + 64'h10, 64'h2, 1, 1, 64'h7, "same_cycle_rw_old");
    vt[13] = mk(BASE + 64'h10, 64'h0, 0, 1, 64'h2, "thr_new");
    vt[14] = mk(BASE + 64'h00, 64'hFF, 1, 1, 64'h0, "pending_ro");
    vt[15] = mk(BASE + 64'h28, 64'h0, 0, 1, 64'h0, "status_rd");

    do_reset();
    chk("rst_vec", interrupt_vector, 4'd0);
    chk("rst_rdata", bus_read_data, 64'h0);
    for (int k = 0; k < 16; k++) begin
      bus_address = vt[k].addr; bus_write_data = vt[k].wdata;
      bus_write_enable = vt[k].wr; bus_read_enable = vt[k].rd;
      tick();
      bus_write_enable = 1'b0; bus_read_enable = 1'b0;
      chk(vt[k].name, bus_read_data, vt[k].exp_rd);
    end

    // T1 basic handshake
    do_reset();
    bus_wr(64'h08, 64'h01); bus_wr(64'h40, 64'h1); bus_wr(64'h10, 64'h0);
    irq_src = 8'h01; tick();
    chk("t1_vec_pending_cycle", interrupt_vector, 4'd0);
    tick();
    chk("t1_vec_up", interrupt_vector, 4'd1);
    interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
    chk("t1_vec_ack", interrupt_vector, 4'd0);
    bus_rd(64'h18); chk("t1_claim", bus_read_data, 64'h1);
    bus_rd(64'h00); chk("t1_pending_clr", bus_read_data, 64'h0);
    bus_wr(64'h20, 64'h1); tick();
    chk("t1_idle_quiet", interrupt_vector, 4'd0);

    // T2 arbitration
    do_reset();
    bus_wr(64'h08, 64'hFF); bus_wr(64'h50, 64'h3); bus_wr(64'h68, 64'h3); bus_wr(64'h48, 64'h2);
    irq_src = 8'h26; tick();
    serve(3, "t2a"); serve(6, "t2b"); serve(2, "t2c");
    bus_rd(64'h00); chk("t2_pending_empty", bus_read_data, 64'h0);

    // T3 threshold and masking
    do_reset();
    bus_wr(64'h08, 64'h01); bus_wr(64'h40, 64'h3); bus_wr(64'h10, 64'h3);
    irq_src = 8'h01; tick(); tick(); tick();
    chk("t3_thr_blocks", interrupt_vector, 4'd0);
    bus_rd(64'h00); chk("t3_pending_latched", bus_read_data, 64'h1);
    bus_wr(64'h10, 64'h2);
    chk("t3_vec_before", interrupt_vector, 4'd0);
    tick();
    chk("t3_thr_lowered", interrupt_vector, 4'd1);
    bus_wr(64'h08, 64'h0);
    chk("t3_vec_mask_cycle", interrupt_vector, 4'd1);
    tick();
    chk("t3_masked_drop", interrupt_vector, 4'd0);

    // T4 complete mismatch and re-edge in service
    do_reset();
    bus_wr(64'h08, 64'h03); bus_wr(64'h40, 64'h1); bus_wr(64'h48, 64'h1);
    irq_src = 8'h01; tick(); tick();
    chk("t4_vec_up", interrupt_vector, 4'd1);
    interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
    irq_src = 8'h00;
    bus_wr(64'h20, 64'h2); tick(); tick();
    chk("t4_mismatch_vec", interrupt_vector, 4'd0);
    bus_rd(64'h18); chk("t4_claim_kept", bus_read_data, 64'h1);
    irq_src = 8'h01; tick();
    bus_rd(64'h00); chk("t4_pending_in_svc", bus_read_data, 64'h1);
    chk("t4_vec_in_svc", interrupt_vector, 4'd0);
    bus_wr(64'h20, 64'h1);
    chk("t4_vec_after_complete", interrupt_vector, 4'd0);
    tick();
    chk("t4_represent", interrupt_vector, 4'd1);

    // T5 races and reset in service
    do_reset();
    bus_wr(64'h08, 64'h01); bus_wr(64'h40, 64'h1);
    irq_src = 8'h01; tick(); tick();
    chk("t5_vec_up", interrupt_vector, 4'd1);
    irq_src = 8'h00; tick();
    irq_src = 8'h01; interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
    chk("t5_vec_ack", interrupt_vector, 4'd0);
    bus_rd(64'h00); chk("t5_set_wins", bus_read_data, 64'h1);
    bus_rd(64'h18); chk("t5_claim", bus_read_data, 64'h1);
    reset = 1'b1; irq_src = 8'h00; tick(); reset = 1'b0;
    chk("t5_rst_vec", interrupt_vector, 4'd0);
    chk("t5_rst_rdata", bus_read_data, 64'h0);
    bus_rd(64'h00); chk("t5_rst_pending", bus_read_data, 64'h0);
    bus_rd(64'h08); chk("t5_rst_enable", bus_read_data, 64'h0);
    bus_rd(64'h18); chk("t5_rst_claim", bus_read_data, 64'h0);
    bus_wr(64'h08, 64'h01); bus_wr(64'h40, 64'h1);
    interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0; tick();
    chk("t5_idle_ack_vec", interrupt_vector, 4'd0);
    irq_src = 8'h01; tick(); tick();
    chk("t5_idle_ack_ignored", interrupt_vector, 4'd1);

`ifdef IRQC_ACK_TIMEOUT_EN
    // T6 ack timeout
    do_reset();
    bus_wr(64'h08, 64'h01); bus_wr(64'h40, 64'h1);
    irq_src = 8'h01; tick(); tick();
    for (int c = 1; c < TO; c++) begin
      chk("t6_vec_held", interrupt_vector, 4'd1);
      tick();
    end
    chk("t6_vec_last", interrupt_vector, 4'd1);
    tick();
    chk("t6_timeout_drop", interrupt_vector, 4'd0);
    tick();
    chk("t6_represent", interrupt_vector, 4'd1);
    bus_rd(64'h28); chk("t6_status_set", bus_read_data, 64'h1);
    bus_wr(64'h08, 64'h0);
    bus_wr(64'h28, 64'h1);
    bus_rd(64'h28); chk("t6_status_clr", bus_read_data, 64'h0);
`endif

    // Random run against the reference model
    do_reset();
    m_reset();
    roffs = '{64'h00, 64'h08, 64'h10, 64'h18, 64'h20, 64'h28, 64'h30, 64'h40, 64'h50, 64'h60, 64'h78, 64'h100};
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [31:0] tg;
      int r;
      logic [63:0] o;
      tg = $urandom & $urandom & $urandom;
      irq_src = irq_src ^ tg[7:0];
      interrupt_ack = ($urandom_range(0, 4) == 0);
      bus_write_enable = 1'b0; bus_read_enable = 1'b0;
      bus_write_data = {$urandom, $urandom};
      o = roffs[$urandom_range(0, 11)];
      r = $urandom_range(0, 15);
      if (r <= 1) o = 64'h08;
      else if (r <= 3) o = 64'h40 + 64'(8 * $urandom_range(0, NS - 1));
      else if (r == 4) begin o = 64'h10; bus_write_data = 64'($urandom_range(0, 3)); end
      else if (r <= 7) begin
        o = 64'h20;
        if ($urandom_range(0, 1) == 1) bus_write_data = 64'(m_claim);
      end
      if (r <= 7 || r == 12) bus_write_enable = 1'b1;
      if ((r >= 8 && r <= 11) || r == 12) bus_read_enable = 1'b1;
      bus_address = BASE + o;
      m_step(irq_src, interrupt_ack, bus_address, bus_write_data, bus_write_enable, bus_read_enable);
      tick();
      chk("rnd_vec", interrupt_vector, 64'(m_st == 1));
      chk("rnd_rdata", bus_read_data, m_rd);
    end
    interrupt_ack = 1'b0; bus_write_enable = 1'b0; bus_read_enable = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
